// File: rtl/network_ctrl_pkg.sv
// Shared types and helpers for the spiking-network sequencer.
// State encoding, width helpers and saturating arithmetic.
package network_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_e;

    // Index width for a class id; a single neuron still needs one bit.
    function automatic int cls_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pointer width for a power-of-two buffer.
    function automatic int ptr_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    localparam int DEF_N_OUT      = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int CLS_W          = cls_width(DEF_N_OUT);
    localparam int PTR_W          = ptr_width(DEF_FIFO_DEPTH);

    // Increment that sticks at max instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max
    );
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/network_ctrl_if.sv
// Bundle of upstream, network-facing and result signals.
// master = environment side, slave = sequencer side.
interface network_ctrl_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int CNT_W = 8
);
    localparam int CW = network_ctrl_pkg::cls_width(N_OUT);

    logic             s_valid;
    logic             s_ready;
    logic [N_IN-1:0]  s_data;
    logic             net_start;
    logic             net_ready;
    logic             net_sample;
    logic             net_sample_ready;
    logic [N_IN-1:0]  net_in_spikes;
    logic [N_OUT-1:0] net_out_spikes;
    logic             res_valid;
    logic             res_ready;
    logic [CW-1:0]    res_class;
    logic [CNT_W-1:0] res_count;

    modport master (
        output s_valid, s_data, net_ready, net_sample,
        output net_out_spikes, res_ready,
        input  s_ready, net_start, net_sample_ready,
        input  net_in_spikes, res_valid, res_class, res_count
    );

    modport slave (
        input  s_valid, s_data, net_ready, net_sample,
        input  net_out_spikes, res_ready,
        output s_ready, net_start, net_sample_ready,
        output net_in_spikes, res_valid, res_class, res_count
    );

endinterface

// File: rtl/spike_fifo.sv
// Small power-of-two FIFO holding input spike vectors.
// Head is combinational from storage and reads 0 when empty.
module spike_fifo
    import network_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data;
    end

    // Pointers wrap naturally; occupancy holds on push+pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/network_ctrl.sv
// Sequencer for the spiking network core: buffers vectors,
// runs one inference per N_SAMPLES vectors, returns argmax.
module network_ctrl
    import network_ctrl_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 2,
    parameter int N_SAMPLES  = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    network_ctrl_if.slave  bus,
    output logic           busy,
    output logic           underrun
);
    localparam int CW   = cls_width(N_OUT);
    localparam int SD_W = $clog2(N_SAMPLES + 1);
    localparam logic [31:0] CNT_MAX =
        32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [SD_W-1:0] SD_FULL = SD_W'(N_SAMPLES);
    localparam logic [SD_W-1:0] SD_LAST = SD_W'(N_SAMPLES - 1);

    state_e           state;
    state_e           state_nxt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [N_IN-1:0]  head;
    logic [SD_W-1:0]  samples_done;
    logic [CNT_W-1:0] cnt     [N_OUT];
    logic [CNT_W-1:0] cnt_nxt [N_OUT];
    logic             counting;
    logic             clear;
    logic             enter_res;
    logic [CW-1:0]    best_cls;
    logic [CNT_W-1:0] best_cnt;

    // s_ready is forced low while reset is held.
    assign bus.s_ready = rst_n & ~full;
    assign push        = bus.s_valid & bus.s_ready;
    assign bus.net_sample_ready = (state == RUN) & ~empty
                                & (samples_done < SD_FULL);
    assign pop         = bus.net_sample & bus.net_sample_ready;
    assign bus.net_in_spikes = head;

    spike_fifo #(
        .WIDTH (N_IN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .data  (bus.s_data),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (bus.net_ready && !empty) state_nxt = START;
            START:
                state_nxt = RUN;
            RUN:
                if (pop && samples_done == SD_LAST) state_nxt = DRAIN;
            DRAIN:
                if (bus.net_ready) state_nxt = RESULT;
            RESULT:
                if (bus.res_ready) state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs and control strobes.
    always_comb begin
        bus.net_start = (state == START);
        bus.res_valid = (state == RESULT);
        busy          = (state != IDLE);
        counting      = (state == RUN) || (state == DRAIN);
        clear         = (state == IDLE) && (state_nxt == START);
        enter_res     = (state == DRAIN) && (state_nxt == RESULT);
    end

    // Samples consumed in the current inference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     samples_done <= '0;
        else if (clear) samples_done <= '0;
        else if (pop)   samples_done <= samples_done + 1'b1;
    end

    // Sticky flag for a sample request against an empty buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) underrun <= 1'b0;
        else if (state == RUN && bus.net_sample && empty)
            underrun <= 1'b1;
    end

    // Counter values including this cycle's spikes.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            cnt_nxt[i] = cnt[i];
            if (counting && bus.net_out_spikes[i])
                cnt_nxt[i] = CNT_W'(sat_inc(32'(cnt[i]), CNT_MAX));
        end
    end

    // Per-neuron spike counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // Argmax over the up-to-date counts; strict > keeps lowest index.
    always_comb begin
        best_cls = '0;
        best_cnt = cnt_nxt[0];
        for (int i = 1; i < N_OUT; i++) begin
            if (cnt_nxt[i] > best_cnt) begin
                best_cnt = cnt_nxt[i];
                best_cls = CW'(i);
            end
        end
    end

    // Result registers captured once on entry to RESULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_class <= '0;
            bus.res_count <= '0;
        end else if (enter_res) begin
            bus.res_class <= best_cls;
            bus.res_count <= best_cnt;
        end
    end

endmodule
